unified_mem_arbiter: RTL

Shares one single-port synchronous SRAM between the CPU fetch port (F stage, read-only) and the data port (M stage, read/write with byte enables). Each cycle it grants at most one requester and returns read data with a registered valid one cycle later. It also drives a stall request back to the pipeline controller. Data accesses have priority, and a starvation guard forces a fetch grant after a bounded number of consecutive data wins.

---
 rtl/unified_mem_arbiter_if.sv | 37 +++
 rtl/unified_mem_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and SRAM signals around the unified memory arbiter.
// The slave modport is the arbiter's view; master is the pipeline/SRAM side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic [3:0]        mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic [15:0]       conflicts;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_w_en, mem_addr, mem_wdata, stall, conflicts
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_w_en, mem_addr, mem_wdata, stall, conflicts
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data access.
// Data wins by default; a starvation counter hands the port to fetch periodically.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input logic                clk,
  input logic                rst,
  unified_mem_arbiter_if.slave bus
);

  typedef enum logic {DM_PRI, IF_PRI} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state, state_nxt;
  owner_t            owner_q, owner_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              if_gnt, dm_gnt, both_req;
  logic              if_rvalid, dm_rvalid;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic [15:0]       conflicts;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign both_req = bus.if_req & bus.dm_req;

  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    state_nxt = DM_PRI;
    cnt_nxt   = cnt;
    owner_nxt = OWN_NONE;
    case (state)
      DM_PRI: begin
        if (bus.dm_req)      dm_gnt = 1'b1;
        else if (bus.if_req) if_gnt = 1'b1;
      end
      IF_PRI: begin
        if (bus.if_req)      if_gnt = 1'b1;
        else if (bus.dm_req) dm_gnt = 1'b1;
      end
      default: ;
    endcase
    // Counter tracks data wins only while fetch is left waiting.
    if (if_gnt || !bus.if_req) cnt_nxt = 4'd0;
    else if (dm_gnt)           cnt_nxt = cnt + 4'd1;
    if (state == DM_PRI && dm_gnt && bus.if_req && cnt_nxt == STARVE_LIM)
      state_nxt = IF_PRI;
    if (if_gnt)                             owner_nxt = OWN_IF;
    else if (dm_gnt && bus.dm_we == 4'd0)   owner_nxt = OWN_DM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= DM_PRI;
      cnt        <= 4'd0;
      owner_q    <= OWN_NONE;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      conflicts  <= 16'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      owner_q <= owner_nxt;
      if (owner_q == OWN_IF) if_rdata_q <= bus.mem_rdata;
      if (owner_q == OWN_DM) dm_rdata_q <= bus.mem_rdata;
      if (both_req) conflicts <= sat_inc(conflicts);
    end
  end

  // SRAM data arrives the cycle after the grant; present it directly while
  // valid, then keep serving the captured copy until the next read.
  assign if_rvalid = (owner_q == OWN_IF);
  assign dm_rvalid = (owner_q == OWN_DM);

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata  = dm_rvalid ? bus.mem_rdata : dm_rdata_q;
  assign bus.mem_addr  = dm_gnt ? bus.dm_addr : bus.if_addr;
  assign bus.mem_w_en  = dm_gnt ? bus.dm_we : 4'd0;
  assign bus.mem_wdata = bus.dm_wdata;
  assign bus.stall     = (bus.if_req & ~if_gnt) | (bus.dm_req & ~dm_gnt);
  assign bus.conflicts = conflicts;

endmodule
